// File: rtl/rst_gen_pkg.sv
// Shared types for the reset generator: sequencer states and reset-cause encoding.
package rst_gen_pkg;

  localparam int unsigned CAUSE_W = 2;

  typedef enum logic [1:0] {
    ASSERT = 2'b00,
    HOLD   = 2'b01,
    RUN    = 2'b10
  } state_t;

  typedef enum logic [CAUSE_W-1:0] {
    CAUSE_PWR = 2'b00,
    CAUSE_SW  = 2'b01,
    CAUSE_EXT = 2'b10
  } cause_t;

endpackage

// File: rtl/rst_gen_sync.sv
// Multi-flop synchronizer, asynchronously cleared to 0 by the board reset.
module sync_chain #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset_async_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge reset_async_n) begin
    if (!reset_async_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/rst_gen.sv
// Reset sequencer: synchronizes board/ext/sw reset sources, stretches every reset
// to HOLD_CYCLES, and reports completion and the cause of the last reset.
module rst_gen
  import rst_gen_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
  input  logic               clk,
  input  logic               reset_async_n,
  input  logic               sw_rst_req_i,
  input  logic               ext_rst_i,
  output logic               rst_sync_o,
  output logic               rst_async_o,
  output logic               rst_done_o,
  output logic [CAUSE_W-1:0] rst_cause_o
);

  logic rel_s;
  logic ext_s;

  sync_chain #(.STAGES(SYNC_STAGES)) u_rel_sync (
    .clk           (clk),
    .reset_async_n (reset_async_n),
    .d_i           (1'b1),
    .q_o           (rel_s)
  );

  sync_chain #(.STAGES(SYNC_STAGES)) u_ext_sync (
    .clk           (clk),
    .reset_async_n (reset_async_n),
    .d_i           (ext_rst_i),
    .q_o           (ext_s)
  );

  state_t           state_q, state_d;
  cause_t           cause_q, cause_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rst_q;
  logic             done_q;

  // Next-state: any request (ext beats sw) restarts the hold window.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ASSERT: begin
        if (rel_s) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        if (ext_s || sw_rst_req_i) begin
          cnt_d   = '0;
          cause_d = ext_s ? CAUSE_EXT : CAUSE_SW;
        end else if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        if (ext_s || sw_rst_req_i) begin
          state_d = HOLD;
          cnt_d   = '0;
          cause_d = ext_s ? CAUSE_EXT : CAUSE_SW;
        end
      end
      default: begin
        state_d = ASSERT;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they change only on clk.
  always_ff @(posedge clk or negedge reset_async_n) begin
    if (!reset_async_n) begin
      state_q <= ASSERT;
      cause_q <= CAUSE_PWR;
      cnt_q   <= '0;
      rst_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
      rst_q   <= (state_d != RUN);
      done_q  <= (state_d == RUN);
    end
  end

  assign rst_sync_o  = rst_q;
  assign rst_async_o = rst_q;
  assign rst_done_o  = done_q;
  assign rst_cause_o = cause_q;

  a_cnt_bound: assert property (@(posedge clk) disable iff (!reset_async_n)
    cnt_q <= CNT_W'(HOLD_CYCLES - 1));

endmodule

// File: doc/rst_gen.md
Name: rst_gen

Overview:
- Reset generator and sequencer that produces the reset signals consumed by the block's flops:
  - an active-high synchronous reset for flops reset on the clock edge;
  - an active-high async-assert/sync-deassert reset for flops with asynchronous reset.
- Takes the raw board reset, a software reset request and an asynchronous external reset request.
- Synchronizes the inputs, stretches every reset to a guaranteed minimum width, and reports the reset cause and completion.

Parameters:
SYNC_STAGES, 2, depth of each synchronizer chain (legal >= 2)
HOLD_CYCLES, 4, minimum cycles reset outputs stay asserted after release/request (legal >= 1)
CNT_W, $clog2(HOLD_CYCLES+1), derived hold-counter width; not to be overridden

Ports:
clk  input  1  single clock, rising edge
reset_async_n  input  1  raw power/board reset, asynchronous, active-low
sw_rst_req_i  input  1  software reset request, synchronous to clk, level sampled each edge
ext_rst_i  input  1  external reset request, asynchronous, active-high
rst_sync_o  output  1  active-high reset for synchronously-reset flops
rst_async_o  output  1  active-high reset for asynchronously-reset flops
rst_done_o  output  1  1 = reset sequence complete, system running
rst_cause_o  output  2  cause of last reset: 00 power, 01 software, 10 external, 11 reserved

Behaviour:
- Reset interface:
  - One clock (clk).
  - Reset is asynchronous and active-low (reset_async_n).
- Power reset (reset_async_n = 0):
  - Takes effect immediately, with no clock edge.
  - Sets state = ASSERT, cnt = 0 and rst_cause_o = 00.
  - Both sync chains clear to 0.
  - rst_sync_o = 1, rst_async_o = 1, rst_done_o = 0.
- Release chain:
  - SYNC_STAGES flops, async-cleared by reset_async_n, shifting in constant 1.
  - The last stage (rel_s) goes high at the SYNC_STAGES-th posedge after reset_async_n rises.
- External chain:
  - SYNC_STAGES flops on ext_rst_i, async-cleared to 0.
  - The last stage is ext_s.
  - No raw ext_rst_i reaches the FSM.
- FSM states: ASSERT, HOLD, RUN. All transitions happen on the posedge.
  - ASSERT: if rel_s = 1, go to HOLD with cnt = 0; otherwise stay.
  - HOLD:
    - if ext_s = 1 or sw_rst_req_i = 1, restart: cnt = 0, stay in HOLD;
    - else if cnt == HOLD_CYCLES-1, go to RUN;
    - else cnt = cnt + 1.
  - RUN:
    - if ext_s = 1, go to HOLD with cnt = 0 and cause = 10;
    - else if sw_rst_req_i = 1, go to HOLD with cnt = 0 and cause = 01;
    - else stay.
- Cause priority and retention:
  - ext over sw when both are present at the same edge.
  - A restart inside HOLD also updates the cause with the same priority.
  - The cause is retained in RUN until the next event.
- Outputs (Moore, decoded from registered state; glitch-free):
  - rst_sync_o = rst_async_o = (state != RUN).
  - rst_done_o = (state == RUN).
- Deassertion timing:
  - From power release, outputs deassert at posedge number SYNC_STAGES+1+HOLD_CYCLES after reset_async_n rises (7 with defaults).
- Request timing:
  - From a request in RUN, outputs assert at the edge sampling the request.
  - They deassert HOLD_CYCLES edges later if no further requests arrive.
  - A held request (sw or ext_s) holds cnt at 0, so outputs stay asserted.
- Mid-operation power reset: reset_async_n low in HOLD or RUN forces ASSERT immediately and clears the cause to 00.
- The counter never exceeds HOLD_CYCLES-1 and never wraps.
- Illegal state encoding: the FSM recovers to ASSERT.

Decomposition:
- Package rst_gen_pkg holds:
  - typedef enum logic [1:0] state_t {ASSERT, HOLD, RUN};
  - typedef enum logic [1:0] cause_t {CAUSE_PWR = 2'b00, CAUSE_SW = 2'b01, CAUSE_EXT = 2'b10}.
- Sub-module sync_chain:
  - parameter STAGES;
  - ports clk, reset_async_n, d_i, q_o;
  - async clear to 0;
  - instantiated twice (release chain with d_i = 1, external chain with d_i = ext_rst_i).

Test Plan:
1. reset_async_n = 0 driven mid-cycle with clk idle -> rst_sync_o = rst_async_o = 1, rst_done_o = 0, cause = 00 immediately. Release -> outputs fall and rst_done_o rises exactly at the 7th posedge.
2. In RUN, sw_rst_req_i high for one cycle -> outputs 1 from that edge, back to 0 at the 4th edge after, rst_cause_o = 01.
3. In RUN, ext_rst_i pulsed high for 3 cycles, unaligned to clk -> outputs assert 2–3 edges later (synchronizer latency), stay high while ext_s = 1, deassert 4 edges after ext_s falls, cause = 10.
4. sw_rst_req_i and ext_s high at the same RUN edge -> HOLD, cause = 10. A sw pulse at cnt = 2 in HOLD -> cnt restarts, deassert 4 edges after the pulse, cause = 01.
5. reset_async_n pulsed low during HOLD (cnt = 2) after a sw reset -> immediate ASSERT, cause = 00, full 7-edge release sequence repeats.
6. Parameter sweep SYNC_STAGES = 3, HOLD_CYCLES = 1 -> power release deasserts at the 5th posedge, a sw request deasserts 1 edge after; a bound assertion checks cnt <= HOLD_CYCLES-1 always.
